// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg
// Shared constants for the fetch-stage branch predictor: EX-stage opcode
// values, 2-bit counter encodings and the counter value loaded on reset.
// No ports (package).
package branch_predictor_pkg;

  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_ALUR   = 4'b1100;
  localparam logic [3:0] OP_ALUI   = 4'b0100;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2
// Next-state function of a 2-bit saturating branch counter.
// Ports:
//   ctr      in  [1:0] current counter value
//   taken    in        resolved branch outcome (1 = taken)
//   ctr_next out [1:0] counter after training, saturating at 00 and 11
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped BTB of 2-bit saturating counters. Lookup of IF_PC is
// combinational; EX-stage branch outcomes train the table on the clock edge.
// Optional build macro BP_BYPASS_EN: a same-cycle lookup of the index being
// written returns the post-update entry instead of the stored one.
// Ports:
//   clk, reset        clock, synchronous active-high table clear
//   IF_PC             fetch address
//   IF_prediction     1 = predict taken
//   IF_predPC         stored target when predicted taken, else IF_PC+4
//   EX_valid          EX instruction valid (not squashed)
//   EX_opcode         EX primary opcode; only OP_BRANCH trains
//   EX_branchPC       address of the resolved branch
//   EX_PC_IMM         resolved branch target
//   EX_condFlag       resolved outcome, 1 = taken
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = DBITS - IDX_BITS - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] IF_PC,
  output logic             IF_prediction,
  output logic [DBITS-1:0] IF_predPC,
  input  logic             EX_valid,
  input  logic [3:0]       EX_opcode,
  input  logic [DBITS-1:0] EX_branchPC,
  input  logic [DBITS-1:0] EX_PC_IMM,
  input  logic             EX_condFlag
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [DBITS-1:0]    target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // Word-aligned PCs: the two low address bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{IF_PC[1:0], EX_branchPC[1:0]};

  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_en;
  logic                upd_hit;
  logic                upd_write;
  logic [1:0]          ctr_trained;

  logic                new_valid;
  logic [TAG_BITS-1:0] new_tag;
  logic [DBITS-1:0]    new_target;
  logic [1:0]          new_ctr;

  assign upd_idx = EX_branchPC[IDX_BITS+1:2];
  assign upd_tag = EX_branchPC[DBITS-1:IDX_BITS+2];
  assign upd_en  = EX_valid && (EX_opcode == OP_BRANCH);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A not-taken miss never writes, so a cold branch cannot evict a live one.
  assign upd_write = upd_en && (upd_hit || EX_condFlag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (EX_condFlag),
    .ctr_next (ctr_trained)
  );

  always_comb begin
    new_valid  = 1'b1;
    new_tag    = upd_tag;
    new_target = EX_condFlag ? EX_PC_IMM : target_q[upd_idx];
    new_ctr    = upd_hit ? ctr_trained : CTR_WT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (upd_write) begin
      valid_q[upd_idx]  <= new_valid;
      tag_q[upd_idx]    <= new_tag;
      target_q[upd_idx] <= new_target;
      ctr_q[upd_idx]    <= new_ctr;
    end
  end

  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic                lk_valid;
  logic [TAG_BITS-1:0] lk_tag;
  logic [DBITS-1:0]    lk_target;
  logic [1:0]          lk_ctr;

  assign rd_idx = IF_PC[IDX_BITS+1:2];
  assign rd_tag = IF_PC[DBITS-1:IDX_BITS+2];

`ifdef BP_BYPASS_EN
  logic fwd;
  // Reset discards the update, so nothing is forwarded during reset.
  assign fwd = upd_write && !reset && (upd_idx == rd_idx);

  always_comb begin
    lk_valid  = fwd ? new_valid  : valid_q[rd_idx];
    lk_tag    = fwd ? new_tag    : tag_q[rd_idx];
    lk_target = fwd ? new_target : target_q[rd_idx];
    lk_ctr    = fwd ? new_ctr    : ctr_q[rd_idx];
  end
`else
  always_comb begin
    lk_valid  = valid_q[rd_idx];
    lk_tag    = tag_q[rd_idx];
    lk_target = target_q[rd_idx];
    lk_ctr    = ctr_q[rd_idx];
  end
`endif

  assign IF_prediction = lk_valid && (lk_tag == rd_tag) && lk_ctr[1];
  assign IF_predPC     = IF_prediction ? lk_target : IF_PC + DBITS'(4);

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor feeding the EX-stage branch handler. Each cycle it looks up IF_PC in a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It drives the taken prediction and the next fetch PC. Branch outcomes resolved in EX train it; the prediction bit is carried down the pipe to the handler, which decides correct/flush.

Parameters:
DBITS, 32, data/address width
IDX_BITS, 6, BTB index width (2^IDX_BITS entries)
TAG_BITS, DBITS-IDX_BITS-2, tag width (PC[DBITS-1:IDX_BITS+2])

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clears the entire table
IF_PC  input  DBITS  current fetch address, word aligned
IF_prediction  output  1  1 = predict taken
IF_predPC  output  DBITS  next fetch PC: stored target if predicted taken, else IF_PC+4
EX_valid  input  1  EX-stage instruction is valid (not squashed)
EX_opcode  input  4  EX-stage primary opcode
EX_branchPC  input  DBITS  address of the EX-stage branch instruction
EX_PC_IMM  input  DBITS  computed branch target
EX_condFlag  input  1  resolved outcome, 1 = taken

Behaviour:
- Entry fields: valid(1), tag(TAG_BITS), target(DBITS), ctr(2). Index = PC[IDX_BITS+1:2]. PC[1:0] ignored.
- Lookup is combinational, zero latency. Hit = valid && tag match. IF_prediction = hit && ctr[1]. IF_predPC = IF_prediction ? target : IF_PC+4. Addition wraps mod 2^DBITS.
- Update fires on the rising clk when EX_valid && EX_opcode==OP_BRANCH (4'b0010). All other opcodes leave the table untouched.
- Update, hit:
  - taken: ctr = min(ctr+1, 3) and target <= EX_PC_IMM.
  - not taken: ctr = max(ctr-1, 0); target unchanged.
- Update, miss:
  - taken: allocate/overwrite the entry with valid=1, new tag, target=EX_PC_IMM, ctr=2'b10 (weakly taken).
  - not taken: no write. Conflicting entries are not evicted by not-taken branches.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Saturation at 0 and 3 is mandatory, with no wrap.
- Reset: on any clk edge with reset=1, all valid<=0 and ctr<=2'b01 in one cycle; any update in that cycle is discarded. Outputs are combinational from the table, so from the first cycle after reset they are IF_prediction=0 and IF_predPC=IF_PC+4. Reset mid-stream simply cold-starts the table; in-flight EX updates after reset deassertion are accepted normally.
- Same-cycle read/write of the same index, without the optional feature: the lookup sees pre-update contents, and the new state is visible the next cycle.
- Pipeline flushes from the branch handler do not touch the table. Squashed instructions arrive with EX_valid=0 and never train.
- No stalls: the table is updated at most once per cycle, with a single write port.

Optional Feature:
BP_BYPASS_EN
- Defined: when an update and a lookup hit the same index in the same cycle, the lookup uses the post-update entry (forwarded combinationally from the EX inputs).
- Undefined: lookup returns stored contents (pre-update), as specified above.
- No port changes either way.

Decomposition:
- Shared package/include: opcode constants (OP_BRANCH=4'b0010, OP_ALUR=4'b1100, OP_ALUI=4'b0100), counter encodings (CTR_SNT/WNT/WT/ST), and the reset counter value.
- One natural sub-module: sat_counter2, the 2-bit saturating next-state function (inputs ctr and taken; output next ctr), instantiated once on the update path.
- The table stays in the top module.

Test Plan:
- Cold start: assert reset 1 cycle, IF_PC=0x00000010 -> IF_prediction=0, IF_predPC=0x00000014.
- Allocate: EX update branchPC=0x10, PC_IMM=0x40, condFlag=1 -> next cycle IF_PC=0x10 gives prediction=1, predPC=0x40.
- Hysteresis and saturation:
  - From ctr=10, apply 3 taken updates -> ctr=11, still predicts taken.
  - Then 1 not-taken update -> ctr=10, still taken.
  - Second not-taken -> 01, prediction=0, predPC=0x14.
  - Third and fourth not-taken -> stays 00.
- Aliasing: with IDX_BITS=6, allocate 0x10 taken, then update 0x110 (same index, different tag) taken to 0x80 -> 0x10 misses (pred 0, 0x14), 0x110 predicts 0x80. A not-taken update of 0x210 leaves 0x110's entry intact.
- Non-branch and squash: EX_opcode=4'b1100 with condFlag=1, or OP_BRANCH with EX_valid=0 -> no table change.
- Same-cycle conflict: IF_PC=0x10 while EX updates 0x10 taken to 0x40 on an empty entry -> same cycle prediction=0 without BP_BYPASS_EN, prediction=1/0x40 with it. Reset asserted in that cycle -> entry stays invalid.
